// File: rtl/mac_tx_ff_reader_pkg.sv
// Shared definitions for the frame FIFO readers: RAM word layout and reader FSM states.
package mac_ff_pkg;

    // Control bit offsets above the data field in a RAM word {sop, eop, be[1:0], data}
    localparam int unsigned SOP_BIT = 3;
    localparam int unsigned EOP_BIT = 2;
    localparam int unsigned BE_LSB  = 0;
    localparam int unsigned BE_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STREAM  = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    function automatic int unsigned word_width(input int unsigned data_width);
        return data_width + 4;
    endfunction

endpackage

// File: rtl/mac_tx_ff_reader_if.sv
// Valid/ready word stream from the transmit FIFO reader to the MAC datapath.
interface mac_tx_ff_reader_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  Tx_valid;
    logic                  Tx_ready;
    logic [DATA_WIDTH-1:0] Tx_data;
    logic [1:0]            Tx_be;
    logic                  Tx_sop;
    logic                  Tx_eop;
    logic                  Tx_abort;

    modport master (
        output Tx_valid, Tx_data, Tx_be, Tx_sop, Tx_eop,
        input  Tx_ready, Tx_abort
    );

    modport slave (
        input  Tx_valid, Tx_data, Tx_be, Tx_sop, Tx_eop,
        output Tx_ready, Tx_abort
    );
endinterface

// File: rtl/mac_tx_ff_reader_skid.sv
// Two-entry in-order word buffer with occupancy count; also exposes next-cycle
// occupancy and tag bit so the owner can register its valid flag.
module mac_ff_skid #(
    parameter int unsigned WIDTH   = 36,
    parameter int unsigned TAG_BIT = WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       occ,
    output logic [1:0]       occ_nxt_c,
    output logic             tag_nxt_c
);

    logic [WIDTH-1:0] ent0_q, ent1_q;
    logic [WIDTH-1:0] ent0_n, ent1_n;
    logic [1:0]       occ_q, occ_n;

    // Callers never pop an empty buffer nor push a full one without popping
    always_comb begin
        ent0_n = ent0_q;
        ent1_n = ent1_q;
        occ_n  = occ_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) ent0_n = din;
                else               ent1_n = din;
                occ_n = occ_q + 2'd1;
            end
            2'b01: begin
                ent0_n = ent1_q;
                occ_n  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    ent0_n = din;
                end else begin
                    ent0_n = ent1_q;
                    ent1_n = din;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_n;
            ent1_q <= ent1_n;
            occ_q  <= occ_n;
        end
    end

    assign head      = ent0_q;
    assign occ       = occ_q;
    assign occ_nxt_c = occ_n;
    assign tag_nxt_c = ent0_n[TAG_BIT];

endmodule

// File: rtl/mac_tx_ff_reader.sv
// Transmit frame FIFO read engine: fetches committed frames from the RAM read
// port and streams them to the MAC, with abort/discard and sop resync.
module mac_tx_ff_reader
    import mac_ff_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic [ADDR_WIDTH:0]     Frame_ptr_wr,
    output logic [ADDR_WIDTH:0]     Rd_ptr,
    output logic [ADDR_WIDTH-1:0]   Ram_addr,
    input  logic [DATA_WIDTH+3:0]   Ram_q,
    mac_tx_ff_reader_if.master      tx,
    output logic                    Err_sync,
    output logic [15:0]             Frames_done
);

    localparam int unsigned WORD_W = word_width(DATA_WIDTH);
    localparam int unsigned PTR_W  = ADDR_WIDTH + 1;
    localparam int unsigned SOP_IX = DATA_WIDTH + SOP_BIT;
    localparam int unsigned EOP_IX = DATA_WIDTH + EOP_BIT;

    state_e             state_q, state_n;
    logic [PTR_W-1:0]   fp_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic               inflight_q;
    logic [15:0]        frames_q;
    logic               err_q;
    logic               valid_q, valid_n;

    logic [WORD_W-1:0]  head;
    logic [1:0]         occ, occ_nxt_c;
    logic               sop_nxt_c;
    logic               h_sop, h_eop;
    logic               accept, discard_pop, pop, drop, frame_end, issue;

    assign h_sop = head[SOP_IX];
    assign h_eop = head[EOP_IX];

    mac_ff_skid #(
        .WIDTH   (WORD_W),
        .TAG_BIT (SOP_IX)
    ) u_skid (
        .clk       (Clk),
        .rst_n     (Rst_n),
        .push      (inflight_q),
        .pop       (pop),
        .din       (Ram_q),
        .head      (head),
        .occ       (occ),
        .occ_nxt_c (occ_nxt_c),
        .tag_nxt_c (sop_nxt_c)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state_q <= ST_IDLE;
        else        state_q <= state_n;
    end

    // Frame FSM, pop selection and read issue
    always_comb begin
        state_n     = state_q;
        discard_pop = 1'b0;
        drop        = 1'b0;
        frame_end   = 1'b0;
        accept      = valid_q & tx.Tx_ready;
        case (state_q)
            ST_IDLE: begin
                if ((occ != 2'd0) && !h_sop) begin
                    drop        = 1'b1;
                    discard_pop = 1'b1;
                end else if (accept) begin
                    if (h_eop) frame_end = 1'b1;
                    else       state_n   = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (accept && h_eop) begin
                    frame_end = 1'b1;
                    state_n   = ST_IDLE;
                end else if (tx.Tx_abort) begin
                    state_n = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (occ != 2'd0) begin
                    discard_pop = 1'b1;
                    if (h_eop) begin
                        frame_end = 1'b1;
                        state_n   = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
        pop   = accept | discard_pop;
        issue = (fp_q != Frame_ptr_wr) &&
                ((3'(occ) + 3'(inflight_q)) < (3'd2 + 3'(pop)));
    end

    // Valid for next cycle, from next-cycle buffer head and state
    always_comb begin
        valid_n = (occ_nxt_c != 2'd0) && (state_n != ST_DISCARD) &&
                  (sop_nxt_c || (state_n == ST_STREAM));
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            fp_q       <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
            frames_q   <= 16'd0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            if (issue) fp_q <= fp_q + PTR_W'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (frame_end) frames_q <= frames_q + 16'd1;
            inflight_q <= issue;
            err_q      <= drop;
            valid_q    <= valid_n;
        end
    end

    assign Ram_addr    = fp_q[ADDR_WIDTH-1:0];
    assign Rd_ptr      = rd_ptr_q;
    assign Frames_done = frames_q;
    assign Err_sync    = err_q;

    assign tx.Tx_valid = valid_q;
    assign tx.Tx_data  = head[DATA_WIDTH-1:0];
    assign tx.Tx_be    = head[DATA_WIDTH+BE_LSB +: BE_W];
    assign tx.Tx_sop   = h_sop;
    assign tx.Tx_eop   = h_eop;

endmodule

// File: tb/tb_mac_tx_ff_reader.sv
// Bench for mac_tx_ff_reader: RAM model, frame writer and scoreboard of expected words.
module tb_mac_tx_ff_reader;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 9;
    localparam int unsigned WW = DW + 4;

    logic          Clk;
    logic          Rst_n;
    logic [AW:0]   Frame_ptr_wr;
    logic [AW:0]   Rd_ptr;
    logic [AW-1:0] Ram_addr;
    logic [WW-1:0] Ram_q;
    logic          Err_sync;
    logic [15:0]   Frames_done;

    mac_tx_ff_reader_if #(.DATA_WIDTH(DW)) tx ();

    mac_tx_ff_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .Frame_ptr_wr (Frame_ptr_wr),
        .Rd_ptr       (Rd_ptr),
        .Ram_addr     (Ram_addr),
        .Ram_q        (Ram_q),
        .tx           (tx),
        .Err_sync     (Err_sync),
        .Frames_done  (Frames_done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [WW-1:0] mem [0:(1<<AW)-1];
    always @(posedge Clk) Ram_q <= mem[Ram_addr];

    int            checks = 0;
    int            errors = 0;
    logic [WW-1:0] exp_q [$];
    logic [AW:0]   wp = '0;
    logic [15:0]   exp_frames = 16'd0;

    // Writes one frame; the first 'keep' words are expected at the output
    task automatic put_frame(input int n, input int keep, input logic [1:0] be_last);
        logic [WW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = {(i == 0), (i == n - 1), (i == n - 1) ? be_last : 2'd0, DW'($urandom)};
            mem[wp[AW-1:0]] = w;
            wp = wp + 1'b1;
            if (i < keep) exp_q.push_back(w);
        end
        exp_frames = exp_frames + 16'd1;
    endtask

    task automatic put_bad();
        mem[wp[AW-1:0]] = {1'b0, 1'b0, 2'd1, DW'($urandom)};
        wp = wp + 1'b1;
    endtask

    task automatic commit();
        @(negedge Clk);
        Frame_ptr_wr = wp;
    endtask

    // Drains the stream, comparing accepted words against the scoreboard
    task automatic run(input int max_cycles, input bit toggle, input int abort_at,
                       output int bubbles, output int accepted, output int errs_seen);
        int cyc = 0, idle = 0, in_frame = 0, n_in;
        bit started = 0, pv = 0, pacc = 0, aborted = 0, acc;
        logic [WW-1:0] w, pw, e;
        bubbles = 0; accepted = 0; errs_seen = 0; pw = '0;
        while (idle < 8) begin
            @(negedge Clk);
            cyc++;
            if (cyc > max_cycles) begin
                checks++; errors++;
                $display("FAIL run_timeout: %0d words still expected after %0d cycles", exp_q.size(), max_cycles);
                break;
            end
            tx.Tx_ready = toggle ? cyc[0] : 1'b1;
            w   = {tx.Tx_sop, tx.Tx_eop, tx.Tx_be, tx.Tx_data};
            acc = tx.Tx_valid && tx.Tx_ready;
            n_in = tx.Tx_sop ? 1 : in_frame + 1;
            tx.Tx_abort = 1'b0;
            if (acc && !aborted && abort_at > 0 && n_in == abort_at) begin
                tx.Tx_abort = 1'b1;
                aborted = 1;
            end
            if (Err_sync) errs_seen++;
            if (pv && !pacc) begin
                checks++;
                if (!tx.Tx_valid || w !== pw) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%0b word=%h, required valid=1 word=%h", tx.Tx_valid, w, pw);
                end
            end
            if (acc) begin
                accepted++;
                in_frame = n_in;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got %h, none expected", w);
                end else begin
                    e = exp_q.pop_front();
                    if (w !== e) begin
                        errors++;
                        $display("FAIL word_data: got %h, required %h", w, e);
                    end
                end
            end
            if (started && !tx.Tx_valid && exp_q.size() > 0) bubbles++;
            if (tx.Tx_valid) started = 1;
            idle = (exp_q.size() == 0) ? idle + 1 : 0;
            pv = tx.Tx_valid; pacc = acc; pw = w;
        end
        tx.Tx_ready = 1'b0;
        tx.Tx_abort = 1'b0;
    endtask

    task automatic check_ptrs(input string name);
        checks++;
        if (Rd_ptr !== wp) begin
            errors++;
            $display("FAIL %s_rd_ptr: got %0d, required %0d", name, Rd_ptr, wp);
        end
        checks++;
        if (Frames_done !== exp_frames) begin
            errors++;
            $display("FAIL %s_frames_done: got %0d, required %0d", name, Frames_done, exp_frames);
        end
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; Frame_ptr_wr = '0; tx.Tx_ready = 1'b0; tx.Tx_abort = 1'b0;
        repeat (3) @(negedge Clk);
        checks++; if (tx.Tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", tx.Tx_valid); end
        checks++; if (Err_sync !== 1'b0) begin errors++; $display("FAIL reset_err_sync: got %b, required 0", Err_sync); end
        checks++; if (Rd_ptr !== '0) begin errors++; $display("FAIL reset_rd_ptr: got %0d, required 0", Rd_ptr); end
        checks++; if (Frames_done !== 16'd0) begin errors++; $display("FAIL reset_frames: got %0d, required 0", Frames_done); end
        checks++; if (Ram_addr !== '0) begin errors++; $display("FAIL reset_ram_addr: got %0d, required 0", Ram_addr); end
        Rst_n = 1'b1;
    endtask

    task automatic test_single_beat();
        int lat = 0, b, a, es;
        put_frame(1, 1, 2'd2);
        commit();
        while (tx.Tx_valid !== 1'b1 && lat < 10) begin
            @(negedge Clk);
            lat++;
        end
        checks++;
        if (lat != 2) begin errors++; $display("FAIL single_latency: got %0d cycles, required 2", lat); end
        checks++;
        if ({tx.Tx_sop, tx.Tx_eop, tx.Tx_be} !== 4'b1110) begin
            errors++;
            $display("FAIL single_fields: sop/eop/be=%b%b%0d, required 1 1 2", tx.Tx_sop, tx.Tx_eop, tx.Tx_be);
        end
        run(40, 1'b0, 0, b, a, es);
        check_ptrs("single");
    endtask

    task automatic test_burst();
        int b, a, es;
        put_frame(8, 8, 2'd3);
        commit();
        run(60, 1'b0, 0, b, a, es);
        checks++; if (b != 0) begin errors++; $display("FAIL burst_bubbles: got %0d, required 0", b); end
        checks++; if (a != 8) begin errors++; $display("FAIL burst_count: got %0d, required 8", a); end
        check_ptrs("burst");
    endtask

    task automatic test_stall();
        int b, a, es;
        put_frame(8, 8, 2'd1);
        commit();
        run(80, 1'b1, 0, b, a, es);
        checks++; if (a != 8) begin errors++; $display("FAIL stall_count: got %0d, required 8", a); end
        check_ptrs("stall");
    endtask

    task automatic test_abort();
        int b, a, es;
        put_frame(10, 3, 2'd0);
        put_frame(2, 2, 2'd2);
        commit();
        run(80, 1'b0, 3, b, a, es);
        checks++; if (a != 5) begin errors++; $display("FAIL abort_count: got %0d, required 5", a); end
        check_ptrs("abort");
    endtask

    task automatic test_bad_sop();
        int b, a, es;
        put_bad();
        put_frame(3, 3, 2'd3);
        commit();
        run(60, 1'b0, 0, b, a, es);
        checks++; if (es != 1) begin errors++; $display("FAIL bad_sop_err_sync: got %0d pulses, required 1", es); end
        checks++; if (a != 3) begin errors++; $display("FAIL bad_sop_count: got %0d, required 3", a); end
        check_ptrs("bad_sop");
    endtask

    task automatic test_wrap();
        int b, a, es, filler;
        logic [AW-1:0] start_addr;
        start_addr = AW'((1 << AW) - 3);
        filler = int'(start_addr) - int'(wp[AW-1:0]);
        put_frame(filler, filler, 2'd0);
        commit();
        run(2 * filler + 60, 1'b0, 0, b, a, es);
        checks++;
        if (Ram_addr !== start_addr) begin errors++; $display("FAIL wrap_start_addr: got %0d, required %0d", Ram_addr, start_addr); end
        put_frame(6, 6, 2'd2);
        commit();
        run(60, 1'b0, 0, b, a, es);
        checks++; if (a != 6) begin errors++; $display("FAIL wrap_count: got %0d, required 6", a); end
        checks++; if (Rd_ptr[AW] !== 1'b1) begin errors++; $display("FAIL wrap_bit: got %b, required 1", Rd_ptr[AW]); end
        check_ptrs("wrap");
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_burst();
        test_stall();
        test_abort();
        test_bad_sop();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
